// File: rtl/i2s_pkg.sv
// Shared types for the I2S TX unpacker: sample-size encodings, FSM states, slice helpers.
// Sign extension of narrow samples is enabled by defining I2S_TX_SIGN_EXT_EN.
package i2s_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {
      SIZE_8    = 2'd0,
      SIZE_16   = 2'd1,
      SIZE_32   = 2'd2,
      SIZE_RSVD = 2'd3
   } size_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Index of the final slice of a word; the reserved encoding behaves as 32-bit.
   function automatic logic [IDX_W-1:0] last_idx(input size_e size);
      case (size)
         SIZE_8:  return IDX_W'(3);
         SIZE_16: return IDX_W'(1);
         default: return IDX_W'(0);
      endcase
   endfunction

endpackage

// File: rtl/i2s_tx_unpacker_if.sv
// Input (packed word) and output (per-sample) stream handshakes of the I2S TX unpacker.
// The unpacker itself uses the slave modport; the producer/consumer side uses master.
interface i2s_tx_unpacker_if;
   import i2s_pkg::*;

   logic [DATA_W-1:0] in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] out_data_o;
   logic              out_valid_o;
   logic              out_ready_i;

   modport slave (
      input  in_data_i, in_valid_i, out_ready_i,
      output in_ready_o, out_data_o, out_valid_o
   );

   modport master (
      output in_data_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_data_o, out_valid_o
   );
endinterface

// File: rtl/i2s_tx_slice_sel.sv
// Picks one slice of the held word and right-aligns it into a full-width sample.
// With I2S_TX_SIGN_EXT_EN defined 8/16-bit samples are sign-extended, else zero-extended.
module i2s_tx_slice_sel
   import i2s_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  size_e             size,
   input  logic              hi_first,
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] data
);

   logic [IDX_W-1:0] pos;
   logic [7:0]       byte_s;
   logic [15:0]      half_s;

   always_comb begin
      pos = hi_first ? IDX_W'(last_idx(size) - idx) : idx;

      case (pos)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         default: byte_s = word[31:24];
      endcase

      half_s = pos[0] ? word[31:16] : word[15:0];

      case (size)
`ifdef I2S_TX_SIGN_EXT_EN
         SIZE_8:  data = {{(DATA_W-8){byte_s[7]}}, byte_s};
         SIZE_16: data = {{(DATA_W-16){half_s[15]}}, half_s};
`else
         SIZE_8:  data = {{(DATA_W-8){1'b0}}, byte_s};
         SIZE_16: data = {{(DATA_W-16){1'b0}}, half_s};
`endif
         default: data = word;
      endcase
   end

endmodule

// File: rtl/i2s_tx_unpacker.sv
// Splits 32-bit uDMA TX words into 8/16/32-bit right-aligned samples for the I2S channel FIFO.
// Optional sign extension of narrow samples: define I2S_TX_SIGN_EXT_EN.
module i2s_tx_unpacker
   import i2s_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_en_i,
   input  logic [1:0]          cfg_size_i,
   input  logic                cfg_hi_first_i,
   i2s_tx_unpacker_if.slave    bus,
   output logic                err_o
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] word_q, word_d;
   size_e             size_q, size_d;
   logic              hi_first_q, hi_first_d;
   logic              err_q, err_d;

   logic [IDX_W-1:0]  last_c;
   logic              in_ready_c;
   logic              out_valid_c;
   logic              in_fire_c;
   logic              out_fire_c;
   logic [DATA_W-1:0] data_c;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         idx_q      <= '0;
         word_q     <= '0;
         size_q     <= SIZE_8;
         hi_first_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         size_q     <= size_d;
         hi_first_q <= hi_first_d;
         err_q      <= err_d;
      end
   end

   // A new word is only accepted when empty or while the last slice of the held word leaves.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      size_d     = size_q;
      hi_first_d = hi_first_q;
      err_d      = 1'b0;

      last_c      = last_idx(size_q);
      out_valid_c = (state_q == ST_FULL);
      in_ready_c  = (state_q == ST_EMPTY) ? cfg_en_i
                  : (cfg_en_i && bus.out_ready_i && (idx_q == last_c));
      in_fire_c   = in_ready_c && bus.in_valid_i;
      out_fire_c  = out_valid_c && bus.out_ready_i;

      if (in_fire_c) begin
         state_d    = ST_FULL;
         idx_d      = '0;
         word_d     = bus.in_data_i;
         size_d     = size_e'(cfg_size_i);
         hi_first_d = cfg_hi_first_i;
         err_d      = (size_e'(cfg_size_i) == SIZE_RSVD);
      end else if (out_fire_c) begin
         if (idx_q != last_c) begin
            idx_d = idx_q + IDX_W'(1);
         end else begin
            state_d = ST_EMPTY;
         end
      end

      // Disable flushes exactly like reset, dropping any held word.
      if (!cfg_en_i) begin
         state_d    = ST_EMPTY;
         idx_d      = '0;
         word_d     = '0;
         size_d     = SIZE_8;
         hi_first_d = 1'b0;
         err_d      = 1'b0;
      end
   end

   i2s_tx_slice_sel u_slice_sel (
      .word     (word_q),
      .size     (size_q),
      .hi_first (hi_first_q),
      .idx      (idx_q),
      .data     (data_c)
   );

   assign bus.in_ready_o  = in_ready_c;
   assign bus.out_valid_o = out_valid_c;
   assign bus.out_data_o  = data_c;
   assign err_o           = err_q;

endmodule
